uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
// - Byte-stream program loader between the UART receiver and the program BRAM write port.
// - Assembles WORD_BYTES-byte words, big-endian (first byte = MSB), into sequential BRAM writes.
// - Detects the end-of-program marker word, then releases the CPU via load_done.
// - Sends a one-byte ACK/NAK back through the UART transmitter.
// - Parametrised successor to the fixed 16-bit loader on the board top: configurable word width, depth, overflow detection, optional checksum.
// PARAMETERS
// - WORD_BYTES  2                   bytes per program word; word width W = 8*WORD_BYTES
// - ADDR_W      10                  program memory address width
// - DEPTH       1024                usable words; must satisfy DEPTH <= 2**ADDR_W
// - END_WORD    {W{1'b1}}           end-of-program marker word; never written to memory
// - ACK_BYTE    8'h06               reply on successful load
// - NAK_BYTE    8'h15               reply on overflow or checksum mismatch
// PORTS
// - sys_clk     in   1         system clock
// - rst_n       in   1         asynchronous active-low reset
// - rx_data     in   8         received byte; valid while rx_data_wr is high
// - rx_data_wr  in   1         one-cycle strobe per received byte
// - mem_addr    out  ADDR_W    program BRAM write address
// - mem_din     out  W         program BRAM write data
// - mem_we      out  1         one-cycle write strobe
// - tx_data     out  8         reply byte; held until the next reply
// - tx_en       out  1         one-cycle strobe to the UART transmitter
// - load_done   out  1         high = program loaded; CPU reset released (cpu rst = ~rst_n | ~load_done)
// - load_err    out  1         sticky error flag for the last load (overflow or bad checksum)
// - word_count  out  ADDR_W+1  number of words written in the current/last load
// BEHAVIOUR
// - Reset values: mem_addr=0, mem_din=0, mem_we=0, tx_data=0, tx_en=0, load_done=0, load_err=0, word_count=0.
// - Reset also sets: state=S_RECV, byte index=0.
// - Reset mid-load abandons the partial word.
// - Byte index counts 0..WORD_BYTES-1; each rx_data_wr shifts rx_data into the LSB of a W-bit shift register.
// - The strobe carrying byte WORD_BYTES-1 completes the word; the index wraps to 0.
// S_RECV, on word completion, registered next cycle (latency 1 clk after the last rx_data_wr):
// - word == END_WORD:
//   - CHECKSUM_EN defined: go to S_CSUM.
//   - Otherwise: go to S_DONE; tx_data = load_err ? NAK_BYTE : ACK_BYTE; tx_en=1.
// - Else if word_count < DEPTH:
//   - mem_din=word, mem_addr=word_count[ADDR_W-1:0], mem_we=1.
//   - word_count increments in the same cycle, so mem_addr of the next write = old value + 1.
// - Else (overflow): no write, load_err=1; word_count saturates at DEPTH. No address wrap.
// S_DONE:
// - load_done=1.
// - Any rx_data_wr starts a new load in the same cycle:
//   - load_done=0, load_err=0, word_count=0, state=S_RECV.
//   - That byte is accepted as byte 0 of the first word.
// - tx_en is a single-cycle pulse; never asserted twice for one load.
// - mem_we and tx_en are never high in the same cycle.
// - A marker word that arrives before any data word is a valid empty program: word_count=0, ACK.
// - rx_data_wr arriving in the same cycle as the mem_we pulse is accepted normally; no byte is ever dropped.
// CONFIGURATION
// - UART_PROG_LOADER_CHECKSUM_EN defined:
//   - An 8-bit running sum (mod 256) accumulates every byte of every non-marker word, including overflowed words.
//   - The sum clears at the start of each load. Marker bytes are excluded.
//   - In S_CSUM, the next received byte is compared with the sum.
//   - Mismatch or load_err: load_err=1, reply NAK_BYTE. Otherwise reply ACK_BYTE.
//   - Then go to S_DONE; tx_en pulses 1 clk after that byte.
// - UART_PROG_LOADER_CHECKSUM_EN undefined: S_CSUM and the sum logic are absent; reply is issued at the marker.
// TESTING
// - Reset, send 12 34 AB CD FF FF:
//   - writes addr0=16'h1234 and addr1=16'hABCD, each mem_we 1 clk after the second byte.
//   - tx_data=06 with tx_en pulse; load_done=1; word_count=2.
// - With DEPTH=2, send 3 words then FF FF:
//   - exactly 2 writes; third word dropped; load_err=1; reply 15; load_done=1.
// - After a completed load, send 00:
//   - load_done falls in the same cycle; then 00 01 FF FF writes addr0=16'h0001; reply 06.
// - WORD_BYTES=4, send DE AD BE EF then FF FF FF FF:
//   - one write 32'hDEADBEEF at addr0; reply 06.
// - CHECKSUM_EN defined, send 01 02 FF FF 03: reply 06. Repeat with final byte 04: reply 15, load_err=1.
// - Assert rst_n low after a single byte of a word, then release and send 00 05 FF FF:
//   - write addr0=16'h0005; no stale byte carried over.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: loads a program into BRAM from a UART byte stream.
// Bytes are assembled big-endian into WORD_BYTES-byte words and written to
// sequential addresses. The END_WORD marker ends the load; an ACK/NAK byte is
// returned through the UART transmitter and load_done releases the CPU.
// Optional feature macro: UART_PROG_LOADER_CHECKSUM_EN -- after the marker,
// one more byte is compared with the mod-256 sum of all data bytes.
// Ports:
//   sys_clk, rst_n          clock, asynchronous active-low reset
//   rx_data, rx_data_wr     received byte and its one-cycle strobe
//   mem_addr/mem_din/mem_we program BRAM write port
//   tx_data, tx_en          reply byte (held) and one-cycle transmit strobe
//   load_done, load_err     program loaded / sticky error of the last load
//   word_count              words written in the current/last load
module uart_prog_loader #(
  parameter int unsigned             WORD_BYTES = 2,
  parameter int unsigned             ADDR_W     = 10,
  parameter int unsigned             DEPTH      = 1024,
  parameter logic [8*WORD_BYTES-1:0] END_WORD   = '1,
  parameter logic [7:0]              ACK_BYTE   = 8'h06,
  parameter logic [7:0]              NAK_BYTE   = 8'h15
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_din,
  output logic                  mem_we,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_W:0]       word_count
);

  localparam int unsigned W     = 8 * WORD_BYTES;
  localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_RECV = 2'd0, S_CSUM = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_RECV = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   byte_idx, byte_idx_nxt;
  logic [W-1:0]       shreg, shreg_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [W-1:0]       mem_din_nxt;
  logic               mem_we_nxt, tx_en_nxt, load_done_nxt, load_err_nxt;
  logic [7:0]         tx_data_nxt;
  logic [ADDR_W:0]    word_count_nxt;

  logic               start_load;
  logic               err_cur;
  logic [ADDR_W:0]    wc_cur;
  logic [W-1:0]       word_c;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  logic [7:0]         csum, csum_nxt;   // sum of all committed data-word bytes
  logic [7:0]         wsum, wsum_nxt;   // sum of bytes of the word in progress
  logic [7:0]         csum_cur;
  logic               csum_bad;
`endif

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RECV;
      byte_idx   <= '0;
      shreg      <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      csum       <= '0;
      wsum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      byte_idx   <= byte_idx_nxt;
      shreg      <= shreg_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      mem_we     <= mem_we_nxt;
      tx_data    <= tx_data_nxt;
      tx_en      <= tx_en_nxt;
      load_done  <= load_done_nxt;
      load_err   <= load_err_nxt;
      word_count <= word_count_nxt;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      csum       <= csum_nxt;
      wsum       <= wsum_nxt;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt      = state;
    byte_idx_nxt   = byte_idx;
    shreg_nxt      = shreg;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    mem_we_nxt     = 1'b0;
    tx_data_nxt    = tx_data;
    tx_en_nxt      = 1'b0;
    load_done_nxt  = load_done;
    load_err_nxt   = load_err;
    word_count_nxt = word_count;
    word_c         = W'({shreg, rx_data});

    // A byte arriving after a completed load opens a new load and is
    // processed as byte 0 in the same cycle, so load state is taken as cleared.
    start_load = (state == S_DONE) && rx_data_wr;
    err_cur    = start_load ? 1'b0 : load_err;
    wc_cur     = start_load ? '0 : word_count;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    csum_nxt   = csum;
    wsum_nxt   = wsum;
    csum_cur   = start_load ? 8'h00 : csum;
    csum_bad   = load_err || (rx_data != csum);
`endif

    if (start_load) begin
      state_nxt      = S_RECV;
      load_done_nxt  = 1'b0;
      load_err_nxt   = 1'b0;
      word_count_nxt = '0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      csum_nxt       = 8'h00;
`endif
    end

    if (rx_data_wr && (state == S_RECV || start_load)) begin
      shreg_nxt = word_c;
      if (byte_idx == LAST_IDX) begin
        byte_idx_nxt = '0;
        if (word_c == END_WORD) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
          state_nxt     = S_CSUM;
          wsum_nxt      = 8'h00;
`else
          state_nxt     = S_DONE;
          load_done_nxt = 1'b1;
          tx_data_nxt   = err_cur ? NAK_BYTE : ACK_BYTE;
          tx_en_nxt     = 1'b1;
`endif
        end else begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
          csum_nxt = csum_cur + wsum + rx_data;
          wsum_nxt = 8'h00;
`endif
          if (wc_cur < DEPTH_W) begin
            mem_din_nxt    = word_c;
            mem_addr_nxt   = wc_cur[ADDR_W-1:0];
            mem_we_nxt     = 1'b1;
            word_count_nxt = wc_cur + 1'b1;
          end else begin
            // Overflow: drop the word, count saturates, no address wrap
            load_err_nxt   = 1'b1;
          end
        end
      end else begin
        byte_idx_nxt = byte_idx + 1'b1;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        wsum_nxt     = wsum + rx_data;
`endif
      end
    end

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    // Checksum byte follows the marker
    if (state == S_CSUM && rx_data_wr) begin
      state_nxt     = S_DONE;
      load_done_nxt = 1'b1;
      load_err_nxt  = csum_bad;
      tx_data_nxt   = csum_bad ? NAK_BYTE : ACK_BYTE;
      tx_en_nxt     = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: two instances (16-bit words with
// DEPTH=2, and 32-bit words). Stimulus pushes expected writes/replies with
// their expected cycle; per-instance monitors pop and compare.
module tb_uart_prog_loader;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data0, rx_data1;
  logic        rx_wr0, rx_wr1;
  logic [9:0]  mem_addr0, mem_addr1;
  logic [15:0] mem_din0;
  logic [31:0] mem_din1;
  logic        mem_we0, mem_we1, tx_en0, tx_en1;
  logic [7:0]  tx_data0, tx_data1;
  logic        load_done0, load_done1, load_err0, load_err1;
  logic [10:0] wc0, wc1;

  always #5 sys_clk = ~sys_clk;

  uart_prog_loader #(.WORD_BYTES(2), .ADDR_W(10), .DEPTH(2)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data0), .rx_data_wr(rx_wr0),
    .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_we(mem_we0),
    .tx_data(tx_data0), .tx_en(tx_en0), .load_done(load_done0),
    .load_err(load_err0), .word_count(wc0));

  uart_prog_loader #(.WORD_BYTES(4), .ADDR_W(10), .DEPTH(1024)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data1), .rx_data_wr(rx_wr1),
    .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_we(mem_we1),
    .tx_data(tx_data1), .tx_en(tx_en1), .load_done(load_done1),
    .load_err(load_err1), .word_count(wc1));

  typedef struct {
    bit          is_reply;
    logic [31:0] val;    // write data or reply byte
    logic [10:0] aw;     // write address or expected word_count
    bit          err;
    longint      cyc;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          n_total = 0;
  int          n_pass  = 0;
  longint      cyc     = 0;
  logic [7:0]  sum0    = 8'h00;
  logic [7:0]  sum1    = 8'h00;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_skew = 8'h00;
`endif

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void mon(input bit sel, input bit we, input bit te,
                              input longint addr, input longint din,
                              input longint txd, input bit ld, input bit le,
                              input longint wc);
    exp_t e;
    string s;
    s = sel ? "1" : "0";
    if (we && te) chk({"we_tx_overlap", s}, 1, 0);
    if (we) begin
      if ((sel ? q1.size() : q0.size()) == 0 || (sel ? q1[0].is_reply : q0[0].is_reply)) begin
        chk({"unexpected_write", s}, addr, -1);
      end else begin
        e = sel ? q1.pop_front() : q0.pop_front();
        chk({"wr_addr", s}, addr, e.aw);
        chk({"wr_data", s}, din, e.val);
        chk({"wr_cycle", s}, cyc, e.cyc);
      end
    end
    if (te) begin
      if ((sel ? q1.size() : q0.size()) == 0 || !(sel ? q1[0].is_reply : q0[0].is_reply)) begin
        chk({"unexpected_reply", s}, txd, -1);
      end else begin
        e = sel ? q1.pop_front() : q0.pop_front();
        chk({"reply_byte", s}, txd, e.val);
        chk({"reply_err", s}, le, e.err);
        chk({"reply_done", s}, ld, 1);
        chk({"reply_wc", s}, wc, e.aw);
        chk({"reply_cycle", s}, cyc, e.cyc);
      end
    end
  endfunction

  always @(negedge sys_clk) begin
    if (rst_n) begin
      mon(1'b0, mem_we0, tx_en0, mem_addr0, mem_din0, tx_data0, load_done0, load_err0, wc0);
      mon(1'b1, mem_we1, tx_en1, mem_addr1, mem_din1, tx_data1, load_done1, load_err1, wc1);
    end
  end

  task automatic push(input bit sel, input bit is_reply, input logic [31:0] val,
                      input logic [10:0] aw, input bit err);
    exp_t e;
    e.is_reply = is_reply; e.val = val; e.aw = aw; e.err = err; e.cyc = cyc + 1;
    if (sel) q1.push_back(e); else q0.push_back(e);
  endtask

  // Called at a negedge; holds the strobe for one cycle, back-to-back capable
  task automatic send_byte(input bit sel, input logic [7:0] b);
    if (sel) begin rx_data1 = b; rx_wr1 = 1'b1; end
    else     begin rx_data0 = b; rx_wr0 = 1'b1; end
    @(negedge sys_clk);
    rx_wr0 = 1'b0;
    rx_wr1 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int nb,
                           input bit wr_exp, input logic [10:0] addr);
    logic [7:0] b;
    for (int i = nb - 1; i >= 0; i--) begin
      b = w[8*i +: 8];
      if (i == 0 && wr_exp) push(sel, 1'b0, w, addr, 1'b0);
      if (sel) sum1 = sum1 + b; else sum0 = sum0 + b;
      send_byte(sel, b);
    end
  endtask

  task automatic end_load(input bit sel, input int nb, input logic [7:0] exp_tx,
                          input bit exp_err, input logic [10:0] exp_wc);
    for (int i = nb - 1; i >= 0; i--) begin
`ifndef UART_PROG_LOADER_CHECKSUM_EN
      if (i == 0) push(sel, 1'b1, 32'(exp_tx), exp_wc, exp_err);
`endif
      send_byte(sel, 8'hFF);
    end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    push(sel, 1'b1, 32'(exp_tx), exp_wc, exp_err);
    send_byte(sel, (sel ? sum1 : sum0) + csum_skew);
`endif
    if (sel) sum1 = 8'h00; else sum0 = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while ((q0.size() != 0 || q1.size() != 0) && n < 20);
    chk({"pending_", name}, q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx_wr0 = 1'b0; rx_wr1 = 1'b0; rx_data0 = 8'h00; rx_data1 = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_mem_din", mem_din0, 0);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_tx_data", tx_data0, 0);
    chk("rst_tx_en", tx_en0, 0);
    chk("rst_load_done", load_done0, 0);
    chk("rst_load_err", load_err0, 0);
    chk("rst_word_count", wc0, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // 12 34 AB CD FF FF: two writes, ACK
    send_word(0, 32'h1234, 2, 1, 11'd0);
    send_word(0, 32'hABCD, 2, 1, 11'd1);
    end_load(0, 2, 8'h06, 0, 11'd2);
    wait_idle("basic");
    chk("basic_load_done", load_done0, 1);
    chk("basic_word_count", wc0, 2);

    // DEPTH=2 overflow: third word dropped, NAK
    send_word(0, 32'h1111, 2, 1, 11'd0);
    chk("newload_done_low", load_done0, 0);
    send_word(0, 32'h2222, 2, 1, 11'd1);
    send_word(0, 32'h3333, 2, 0, 11'd0);
    end_load(0, 2, 8'h15, 1, 11'd2);
    wait_idle("overflow");
    chk("ovf_load_err", load_err0, 1);
    chk("ovf_load_done", load_done0, 1);
    chk("ovf_word_count", wc0, 2);

    // Restart after load: load_done and load_err clear on the first byte
    send_byte(0, 8'h00);
    chk("restart_done_low", load_done0, 0);
    chk("restart_err_clear", load_err0, 0);
    chk("restart_wc_clear", wc0, 0);
    push(0, 1'b0, 32'h0001, 11'd0, 1'b0);
    send_byte(0, 8'h01);
    sum0 = 8'h01;
    end_load(0, 2, 8'h06, 0, 11'd1);
    wait_idle("restart");

    // Empty program: marker only
    end_load(0, 2, 8'h06, 0, 11'd0);
    wait_idle("empty");
    chk("empty_word_count", wc0, 0);

    // 32-bit words
    send_word(1, 32'hDEADBEEF, 4, 1, 11'd0);
    end_load(1, 4, 8'h06, 0, 11'd1);
    wait_idle("wide");
    chk("wide_load_done", load_done1, 1);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    // 01 02 FF FF 03 -> ACK; 01 02 FF FF 04 -> NAK
    send_word(0, 32'h0102, 2, 1, 11'd0);
    end_load(0, 2, 8'h06, 0, 11'd1);
    wait_idle("csum_good");
    csum_skew = 8'h01;
    send_word(0, 32'h0102, 2, 1, 11'd0);
    end_load(0, 2, 8'h15, 1, 11'd1);
    wait_idle("csum_bad");
    chk("csum_bad_err", load_err0, 1);
    csum_skew = 8'h00;
`endif

    // Reset mid-word discards the partial byte
    send_byte(0, 8'hAA);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midrst_load_done", load_done0, 0);
    chk("midrst_word_count", wc0, 0);
    chk("midrst_tx_data", tx_data0, 0);
    chk("midrst_mem_we", mem_we0, 0);
    rst_n = 1'b1;
    sum0 = 8'h00;
    sum1 = 8'h00;
    @(negedge sys_clk);
    send_word(0, 32'h0005, 2, 1, 11'd0);
    end_load(0, 2, 8'h06, 0, 11'd1);
    wait_idle("midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
